// File: rtl/expr_pkg.sv
// Shared definitions for the expression recogniser / evaluator pair.
//   CH_*     : ASCII codes of the accepted characters
//   state_t  : evaluator FSM states (2-bit encoding)
//   op_t     : pending operator applied to the next digit
package expr_pkg;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_NUM   = 2'd1,
    ST_OPR   = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  typedef enum logic {
    ADD = 1'b0,
    MUL = 1'b1
  } op_t;

endpackage

// File: rtl/expr_eval_if.sv
// Character-stream / result bundle for expr_eval.
//   in, in_vld             : ASCII character and its valid strobe (master -> slave)
//   ok, val, res, done,
//   ovf, err               : evaluator status and results (slave -> master)
interface expr_eval_if #(
  parameter int unsigned W = 8
);
  logic [7:0]   in;
  logic         in_vld;
  logic         ok;
  logic [W-1:0] val;
  logic [W-1:0] res;
  logic         done;
  logic         ovf;
  logic         err;

  modport master (output in, in_vld, input  ok, val, res, done, ovf, err);
  modport slave  (input  in, in_vld, output ok, val, res, done, ovf, err);
endinterface

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier shared by the recogniser and the evaluator.
//   in     : ASCII character
//   is_dig : '0'..'9'      digit : numeric value when is_dig, else 0
//   is_op  : '+' or '*'    is_mul: '*'
//   is_eq  : '='
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_dig,
  output logic       is_op,
  output logic       is_mul,
  output logic       is_eq,
  output logic [3:0] digit
);
  always_comb begin
    is_dig = (in >= CH_0) && (in <= CH_9);
    is_mul = (in == CH_MUL);
    is_op  = is_mul || (in == CH_ADD);
    is_eq  = (in == CH_EQ);
    // low nibble of 0x30..0x39 is the digit value
    digit  = is_dig ? in[3:0] : '0;
  end
endmodule

// File: rtl/expr_eval.sv
// Evaluates single-digit '+'/'*' expressions terminated by '=', with '*'
// binding tighter than '+'. All arithmetic is modulo 2^W.
//   clk : clock, rising edge        clr : asynchronous active-high reset
//   bus : expr_eval_if slave - in/in_vld in; ok/val/res/done/ovf/err out
module expr_eval
  import expr_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic       clk,
  input  logic       clr,
  expr_eval_if.slave bus
);
  logic         is_dig, is_op, is_mul, is_eq;
  logic [3:0]   digit;

  expr_char_class u_class (
    .in     (bus.in),
    .is_dig (is_dig),
    .is_op  (is_op),
    .is_mul (is_mul),
    .is_eq  (is_eq),
    .digit  (digit)
  );

  state_t       state_q;
  op_t          nxt_q;
  logic [W-1:0] sum_q, term_q, val_q, res_q;
  logic         ok_q, done_q, ovf_q, err_q;

  logic [W-1:0]   digit_w;
  logic [2*W-1:0] prod_d;
  logic [W-1:0]   term_d;
  logic           prod_ovf_d;
  logic [W:0]     sum_add_d;
  logic [W:0]     val_sum_d;

  // Candidate arithmetic results; the FSM decides which ones commit.
  always_comb begin
    digit_w    = W'(digit);
    prod_d     = (2*W)'(term_q) * (2*W)'(digit);
    prod_ovf_d = 1'b0;
    term_d     = digit_w;
    if (state_q == ST_OPR && nxt_q == MUL) begin
      term_d     = prod_d[W-1:0];
      prod_ovf_d = |prod_d[2*W-1:W];
    end
    sum_add_d = {1'b0, sum_q} + {1'b0, term_q};
    val_sum_d = {1'b0, sum_q} + {1'b0, term_d};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_START;
      nxt_q   <= ADD;
      sum_q   <= '0;
      term_q  <= '0;
      val_q   <= '0;
      res_q   <= '0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.in_vld) begin
        case (state_q)
          ST_START: begin
            if (is_dig) begin
              state_q <= ST_NUM;
              term_q  <= term_d;
              val_q   <= val_sum_d[W-1:0];
              ok_q    <= 1'b1;
              // first digit of a new expression discards the previous ovf
              ovf_q   <= val_sum_d[W];
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
              ok_q    <= 1'b0;
            end
          end
          ST_NUM: begin
            if (is_op) begin
              state_q <= ST_OPR;
              ok_q    <= 1'b0;
              if (is_mul) begin
                nxt_q <= MUL;
              end else begin
                nxt_q <= ADD;
                sum_q <= sum_add_d[W-1:0];
                ovf_q <= ovf_q | sum_add_d[W];
              end
            end else if (is_eq) begin
              state_q <= ST_START;
              res_q   <= val_q;
              done_q  <= 1'b1;
              ok_q    <= 1'b0;
              sum_q   <= '0;
              term_q  <= '0;
              nxt_q   <= ADD;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
              ok_q    <= 1'b0;
            end
          end
          ST_OPR: begin
            if (is_dig) begin
              state_q <= ST_NUM;
              ok_q    <= 1'b1;
              term_q  <= term_d;
              val_q   <= val_sum_d[W-1:0];
              ovf_q   <= ovf_q | prod_ovf_d | val_sum_d[W];
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
              ok_q    <= 1'b0;
            end
          end
          ST_ERR: begin
            err_q <= 1'b1;
            ok_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
            ok_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ok   = ok_q;
  assign bus.val  = val_q;
  assign bus.res  = res_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.err  = err_q;

endmodule
